// File: rtl/adc_pkg.sv
// Shared helpers for the ADC capture path: sample format conversion, clip
// detection, MSB alignment and saturating counters, written for any width up to MAX_W.
package adc_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  // Ones in the low w bits.
  function automatic word_t field_mask(input int w);
    if (w >= MAX_W) return '1;
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Offset binary becomes two's complement by flipping the field MSB.
  function automatic word_t to_twos(input word_t raw, input int w, input logic twos);
    word_t v;
    v = raw & field_mask(w);
    if (!twos) v = v ^ (word_t'(1) << (w - 1));
    return v;
  endfunction

  // Clipped when the out-of-range pin is set or the code sits on either rail.
  function automatic logic is_clip(input word_t v, input int w, input logic or_pin);
    word_t m;
    word_t max_pos;
    word_t min_neg;
    m       = v & field_mask(w);
    max_pos = field_mask(w) >> 1;
    min_neg = word_t'(1) << (w - 1);
    return or_pin | (m == max_pos) | (m == min_neg);
  endfunction

  function automatic word_t msb_align(input word_t v, input int in_w, input int out_w);
    return (v & field_mask(in_w)) << (out_w - in_w);
  endfunction

  function automatic word_t sat_inc(input word_t c, input int w);
    word_t m;
    m = c & field_mask(w);
    if (m == field_mask(w)) return m;
    return m + word_t'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra MSB so
// full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so the output is defined after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_fifo.sv
// ADC capture front end: strobe-qualified sample register with format
// conversion and clip detect, FWFT buffer toward the DSP chain, and status.
module adc_capture_fifo
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH  = 10,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_enable,
  input  logic                          cfg_twos_comp,
  input  logic [ADC_WIDTH-1:0]          adc_data,
  input  logic                          adc_valid,
  input  logic                          adc_or,
  output logic [OUT_WIDTH-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky,
  input  logic                          ovf_clear,
  output logic [CNT_WIDTH-1:0]          clip_count,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  logic                 s1_valid;
  logic [ADC_WIDTH-1:0] s1_data;
  logic                 s1_clip;
  word_t                conv_w;
  logic                 cap_clip;
  logic [OUT_WIDTH-1:0] aligned;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 clip_evt;
  logic                 drop_evt;

  always_comb begin
    conv_w   = to_twos(word_t'(adc_data), ADC_WIDTH, cfg_twos_comp);
    cap_clip = is_clip(conv_w, ADC_WIDTH, adc_or);
    aligned  = OUT_WIDTH'(msb_align(word_t'(s1_data), ADC_WIDTH, OUT_WIDTH));
  end

  // Stage 1 only loads on an enabled strobe; a sample already here always moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_clip  <= 1'b0;
    end else begin
      s1_valid <= adc_valid && cfg_enable;
      if (adc_valid && cfg_enable) begin
        s1_data <= ADC_WIDTH'(conv_w);
        s1_clip <= cap_clip;
      end
    end
  end

  // Output handshake: a beat transfers on a rising edge where m_valid and
  // m_ready are both high; while m_valid is high and m_ready low the head
  // (m_data) and m_valid stay unchanged.
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid),
    .push_data (aligned),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (m_data),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign clip_evt = s1_valid && s1_clip;
  assign drop_evt = s1_valid && fifo_full && !pop;

  // A same-cycle event outranks the clear, so nothing is lost from status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      clip_count <= '0;
      drop_count <= '0;
    end else begin
      if (clip_evt || drop_evt) ovf_sticky <= 1'b1;
      else if (ovf_clear)       ovf_sticky <= 1'b0;

      if (ovf_clear)     clip_count <= CNT_WIDTH'(clip_evt);
      else if (clip_evt) clip_count <= CNT_WIDTH'(sat_inc(word_t'(clip_count), CNT_WIDTH));

      if (ovf_clear)     drop_count <= CNT_WIDTH'(drop_evt);
      else if (drop_evt) drop_count <= CNT_WIDTH'(sat_inc(word_t'(drop_count), CNT_WIDTH));
    end
  end

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed bench for adc_capture_fifo: scoreboard of expected output samples,
// status checks after each scenario, one summary line at the end.
module tb_adc_capture_fifo;

  localparam int ADC_WIDTH  = 10;
  localparam int OUT_WIDTH  = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_enable;
  logic                 cfg_twos_comp;
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_valid;
  logic                 adc_or;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [LW-1:0]        fifo_level;
  logic                 ovf_sticky;
  logic                 ovf_clear;
  logic [CNT_WIDTH-1:0] clip_count;
  logic [CNT_WIDTH-1:0] drop_count;

  logic [OUT_WIDTH-1:0] exp_q[$];
  int pass_cnt;
  int total_cnt;

  adc_capture_fifo #(
    .ADC_WIDTH  (ADC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_twos_comp (cfg_twos_comp),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .adc_or        (adc_or),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_level    (fifo_level),
    .ovf_sticky    (ovf_sticky),
    .ovf_clear     (ovf_clear),
    .clip_count    (clip_count),
    .drop_count    (drop_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [OUT_WIDTH-1:0] model(input logic [ADC_WIDTH-1:0] raw,
                                                 input logic twos);
    logic [ADC_WIDTH-1:0] c;
    c = raw;
    if (!twos) c[ADC_WIDTH-1] = ~raw[ADC_WIDTH-1];
    return {c, {(OUT_WIDTH-ADC_WIDTH){1'b0}}};
  endfunction

  // Called just after an edge: inputs now set are taken at the next edge,
  // and a beat shown with m_ready high is consumed there.
  task automatic tick();
    logic [OUT_WIDTH-1:0] e;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {16'h0, m_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_m_data", {16'h0, m_data}, {16'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [ADC_WIDTH-1:0] d, input logic orp, input logic expect_write);
    adc_valid = 1'b1;
    adc_data  = d;
    adc_or    = orp;
    if (expect_write && cfg_enable) exp_q.push_back(model(d, cfg_twos_comp));
    tick();
    adc_valid = 1'b0;
    adc_or    = 1'b0;
  endtask

  task automatic clear_status();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [ADC_WIDTH-1:0] r;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    cfg_enable    = 1'b0;
    cfg_twos_comp = 1'b0;
    adc_data      = '0;
    adc_valid     = 1'b0;
    adc_or        = 1'b0;
    m_ready       = 1'b0;
    ovf_clear     = 1'b0;
    @(posedge clk); #1;
    ticks(2);

    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_clip", clip_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_m_data", m_data, 0);

    rst_n      = 1'b1;
    cfg_enable = 1'b1;
    m_ready    = 1'b1;
    tick();

    // Offset binary: rails clip, mid-scale maps to zero.
    send(10'h3FF, 1'b0, 1'b1);
    send(10'h200, 1'b0, 1'b1);
    send(10'h000, 1'b0, 1'b1);
    send(10'h100, 1'b0, 1'b1);
    ticks(4);
    chk("ob_drained", exp_q.size(), 0);
    chk("ob_clip_count", clip_count, 2);
    chk("ob_ovf", ovf_sticky, 1);
    chk("ob_drop_count", drop_count, 0);
    clear_status();
    chk("clr_clip", clip_count, 0);
    chk("clr_ovf", ovf_sticky, 0);

    // Two's complement: positive rail and out-of-range pin both clip.
    cfg_twos_comp = 1'b1;
    send(10'h1FF, 1'b0, 1'b1);
    send(10'h005, 1'b1, 1'b1);
    ticks(4);
    chk("tc_drained", exp_q.size(), 0);
    chk("tc_clip_count", clip_count, 2);
    clear_status();

    // Disabled: strobes are ignored.
    cfg_enable = 1'b0;
    send(10'h055, 1'b0, 1'b0);
    ticks(3);
    chk("dis_level", fifo_level, 0);
    chk("dis_m_valid", m_valid, 0);
    cfg_enable = 1'b1;

    // Backpressure: 20 strobes into 16 entries.
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = 10'($urandom_range(1, 10'h1FE));
      send(r, 1'b0, i < FIFO_DEPTH);
    end
    ticks(2);
    chk("bp_level", fifo_level, FIFO_DEPTH);
    chk("bp_drop", drop_count, 4);
    chk("bp_m_valid", m_valid, 1);

    // Full with a pop in the same cycle as the write: accepted, no drop.
    send(10'h0AA, 1'b0, 1'b1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("fullpop_level", fifo_level, FIFO_DEPTH);
    chk("fullpop_drop", drop_count, 4);

    // Clear coinciding with a drop: event wins.
    send(10'h0BB, 1'b0, 1'b0);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("clrdrop_ovf", ovf_sticky, 1);
    chk("clrdrop_drop", drop_count, 1);

    m_ready = 1'b1;
    ticks(FIFO_DEPTH + 2);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_empty", m_valid, 0);

    // Sustained one sample per cycle with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      r = 10'($urandom_range(1, 10'h1FE));
      send(r, 1'b0, 1'b1);
      chk("tput_level_le1", fifo_level <= 1, 1);
    end
    ticks(3);
    chk("tput_drained", exp_q.size(), 0);
    chk("tput_drop", drop_count, 1);

    // Reset with 5 buffered entries.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(10'(i + 3), 1'b0, 1'b1);
    ticks(2);
    chk("pre_rst_level", fifo_level, 5);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_ovf", ovf_sticky, 0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();

    // First sample after reset: visible two edges after its strobe.
    send(10'h123, 1'b0, 1'b1);
    chk("lat_edge1_m_valid", m_valid, 0);
    tick();
    chk("lat_edge2_m_valid", m_valid, 1);
    ticks(3);
    chk("post_rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
